uart_word_bridge: RTL and testbench

UART_WORD_BRIDGE -- requirements
Module: uart_word_bridge

---
 rtl/uart_word_bridge.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_uart_word_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_bridge.sv
// rtl/uart_word_bridge.sv - UART 8N1 bridge: RX bytes assembled into words, TX words queued and serialized
module uart_word_bridge #(
    parameter int WORD_BYTES     = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int STP_BITS_TICKS = 16,
    localparam int WORD_BITS     = 8 * WORD_BYTES
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_bd_tick,
    input  logic                 i_rx,
    output logic                 o_tx,
    input  logic                 i_wr_en,
    input  logic [WORD_BITS-1:0] i_wr_data,
    output logic                 o_full,
    output logic                 o_overflow,
    output logic                 o_tx_busy,
    output logic                 o_rx_valid,
    output logic [WORD_BITS-1:0] o_rx_data,
    output logic                 o_rx_frame_err
);

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int TW  = (STP_BITS_TICKS > 16) ? $clog2(STP_BITS_TICKS) : 4;
    localparam int BIW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [TW-1:0]  TICK_MID   = TW'(7);
    localparam logic [TW-1:0]  TICK_LAST  = TW'(15);
    localparam logic [TW-1:0]  TICK_STOP  = TW'(STP_BITS_TICKS - 1);
    localparam logic [BIW-1:0] BYTE_LAST  = BIW'(WORD_BYTES - 1);
    localparam logic [CW-1:0]  COUNT_FULL = CW'(FIFO_DEPTH);

    // ---------------- receiver ----------------
    logic [1:0]           r_rx_state;
    logic [TW-1:0]        r_rx_tick;
    logic [2:0]           r_rx_bit;
    logic [7:0]           r_rx_shift;
    logic [BIW-1:0]       r_rx_idx;
    logic [WORD_BITS-1:0] r_rx_word;
    logic [WORD_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_err;
    logic [WORD_BITS-1:0] w_rx_merged;

    // Partial word with the just-received byte dropped into its little-endian slot
    always_comb begin
        w_rx_merged = r_rx_word;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (r_rx_idx == BIW'(k)) begin
                w_rx_merged[8*k +: 8] = r_rx_shift;
            end
        end
    end

    // RX FSM: start-bit qualification, mid-bit sampling, stop check and word assembly
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_state <= S_IDLE;
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_idx   <= '0;
            r_rx_word  <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            case (r_rx_state)
                S_IDLE: begin
                    if (!i_rx) begin
                        r_rx_state <= S_START;
                        r_rx_tick  <= '0;
                    end
                end
                S_START: begin
                    if (i_bd_tick) begin
                        if (r_rx_tick == TICK_MID) begin
                            if (i_rx) begin
                                r_rx_state <= S_IDLE;
                            end else begin
                                r_rx_state <= S_DATA;
                                r_rx_tick  <= '0;
                                r_rx_bit   <= '0;
                            end
                        end else begin
                            r_rx_tick <= r_rx_tick + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (i_bd_tick) begin
                        if (r_rx_tick == TICK_LAST) begin
                            r_rx_tick  <= '0;
                            r_rx_shift <= {i_rx, r_rx_shift[7:1]};
                            if (r_rx_bit == 3'd7) begin
                                r_rx_state <= S_STOP;
                            end else begin
                                r_rx_bit <= r_rx_bit + 3'd1;
                            end
                        end else begin
                            r_rx_tick <= r_rx_tick + TW'(1);
                        end
                    end
                end
                default: begin
                    if (i_bd_tick) begin
                        if (r_rx_tick == TICK_STOP) begin
                            r_rx_state <= S_IDLE;
                            if (i_rx) begin
                                if (r_rx_idx == BYTE_LAST) begin
                                    r_rx_data  <= w_rx_merged;
                                    r_rx_valid <= 1'b1;
                                    r_rx_idx   <= '0;
                                    r_rx_word  <= '0;
                                end else begin
                                    r_rx_word <= w_rx_merged;
                                    r_rx_idx  <= r_rx_idx + BIW'(1);
                                end
                            end else begin
                                // Bad stop bit: the whole word in progress is untrustworthy
                                r_rx_err  <= 1'b1;
                                r_rx_word <= '0;
                                r_rx_idx  <= '0;
                            end
                        end else begin
                            r_rx_tick <= r_rx_tick + TW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- TX FIFO ----------------
    logic [WORD_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_full;
    logic                 r_overflow;
    logic [CW-1:0]        w_count_next;
    logic                 w_push;
    logic                 w_pop;

    assign w_push = i_wr_en && !r_full;

    // Occupancy after this cycle's push/pop; a push while full never counts
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; full is registered from the new count
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count    <= w_count_next;
            r_full     <= (w_count_next == COUNT_FULL);
            r_overflow <= i_wr_en && r_full;
        end
    end

    // ---------------- transmitter ----------------
    logic [1:0]           r_tx_state;
    logic [TW-1:0]        r_tx_tick;
    logic [2:0]           r_tx_bit;
    logic [BIW-1:0]       r_tx_idx;
    logic [WORD_BITS-1:0] r_tx_word;
    logic                 r_tx_rearm;
    logic                 w_tx_line;

    // A fresh word starts on a baud tick, so TX stays parked while ticks are withheld;
    // right after a word ends the next queued word is taken immediately
    assign w_pop = (r_tx_state == S_IDLE) && (r_count != '0) && (i_bd_tick || r_tx_rearm);

    // TX FSM: the word register shifts right one bit per data bit, so the next byte
    // is already in the low bits when its START begins
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= S_IDLE;
            r_tx_tick  <= '0;
            r_tx_bit   <= '0;
            r_tx_idx   <= '0;
            r_tx_word  <= '0;
            r_tx_rearm <= 1'b0;
        end else begin
            r_tx_rearm <= 1'b0;
            case (r_tx_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_word  <= r_mem[r_rd_ptr];
                        r_tx_idx   <= '0;
                        r_tx_tick  <= '0;
                        r_tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (i_bd_tick) begin
                        if (r_tx_tick == TICK_LAST) begin
                            r_tx_tick  <= '0;
                            r_tx_bit   <= '0;
                            r_tx_state <= S_DATA;
                        end else begin
                            r_tx_tick <= r_tx_tick + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (i_bd_tick) begin
                        if (r_tx_tick == TICK_LAST) begin
                            r_tx_tick <= '0;
                            r_tx_word <= r_tx_word >> 1;
                            if (r_tx_bit == 3'd7) begin
                                r_tx_state <= S_STOP;
                            end else begin
                                r_tx_bit <= r_tx_bit + 3'd1;
                            end
                        end else begin
                            r_tx_tick <= r_tx_tick + TW'(1);
                        end
                    end
                end
                default: begin
                    if (i_bd_tick) begin
                        if (r_tx_tick == TICK_STOP) begin
                            r_tx_tick <= '0;
                            if (r_tx_idx != BYTE_LAST) begin
                                r_tx_idx   <= r_tx_idx + BIW'(1);
                                r_tx_state <= S_START;
                            end else begin
                                r_tx_state <= S_IDLE;
                                r_tx_rearm <= 1'b1;
                            end
                        end else begin
                            r_tx_tick <= r_tx_tick + TW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Line level follows the FSM state; idle and stop are both mark
    always_comb begin
        w_tx_line = 1'b1;
        if (r_tx_state == S_START) begin
            w_tx_line = 1'b0;
        end else if (r_tx_state == S_DATA) begin
            w_tx_line = r_tx_word[0];
        end
    end

    assign o_tx           = w_tx_line;
    assign o_tx_busy      = (r_tx_state != S_IDLE) || w_pop;
    assign o_full         = r_full;
    assign o_overflow     = r_overflow;
    assign o_rx_valid     = r_rx_valid;
    assign o_rx_data      = r_rx_data;
    assign o_rx_frame_err = r_rx_err;

endmodule

// File: tb/tb_uart_word_bridge.sv
// tb/tb_uart_word_bridge.sv - directed self-checking bench for uart_word_bridge
module tb_uart_word_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bd_tick = 1'b0;
    logic        rx = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        tx, full, overflow, tx_busy, rx_valid, rx_err;
    logic [31:0] rx_data;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          tick_en = 1'b0;
    int          tick_num = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;
    int          tx_badstop = 0;
    logic [7:0]  tx_bytes[$];
    int          tx_starts[$];
    logic [31:0] words [9];

    uart_word_bridge #(
        .WORD_BYTES(4),
        .FIFO_DEPTH(8),
        .STP_BITS_TICKS(16)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_bd_tick(bd_tick),
        .i_rx(rx),
        .o_tx(tx),
        .i_wr_en(wr_en),
        .i_wr_data(wr_data),
        .o_full(full),
        .o_overflow(overflow),
        .o_tx_busy(tx_busy),
        .o_rx_valid(rx_valid),
        .o_rx_data(rx_data),
        .o_rx_frame_err(rx_err)
    );

    always #5 clk = ~clk;

    // Baud tick every second clock, changed just after the rising edge
    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                div = div + 1;
                bd_tick = (div % 2 == 0);
            end else begin
                div = 0;
                bd_tick = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (bd_tick) tick_num <= tick_num + 1;
    end

    always @(negedge clk) begin
        if (rx_valid) valid_cnt <= valid_cnt + 1;
        if (rx_err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (bd_tick !== 1'b1) @(posedge clk);
        end
    endtask

    // Serial decoder for o_tx: samples mid-bit, records byte and start tick
    initial begin : tx_mon
        logic [7:0] b;
        int         st;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                st = tick_num;
                wait_ticks(8);
                #1;
                if (tx !== 1'b0) tx_badstop++;
                for (int i = 0; i < 8; i++) begin
                    wait_ticks(16);
                    #1;
                    b[i] = tx;
                end
                wait_ticks(16);
                #1;
                if (tx !== 1'b1) tx_badstop++;
                tx_bytes.push_back(b);
                tx_starts.push_back(st);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(posedge clk);
        #1;
        rx = 1'b0;
        wait_ticks(16);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_ticks(16);
            #1;
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_ticks(16);
            #1;
        end else begin
            rx = 1'b0;
            wait_ticks(10);
            #1;
            rx = 1'b1;
            wait_ticks(6);
            #1;
        end
        rx = 1'b1;
        wait_ticks(16);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin : main
        bit any_busy;
        int c;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_frame_err", rx_err, 0);
        chk("rst_rx_data", rx_data, 0);

        tick_en = 1'b1;

        // Short low pulse on rx must be rejected as a glitch
        @(posedge clk);
        #1;
        rx = 1'b0;
        wait_ticks(4);
        #1;
        rx = 1'b1;
        wait_ticks(32);
        @(negedge clk);
        chk("glitch_valid", valid_cnt, 0);
        chk("glitch_err", err_cnt, 0);

        // Little-endian word assembly
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        chk("rx_no_early_valid", valid_cnt, 0);
        send_byte(8'h12, 1'b1);
        chk("rx_valid_count", valid_cnt, 1);
        chk("rx_word", rx_data, 32'h1234_5678);
        chk("rx_no_err", err_cnt, 0);

        // Framing error discards the partial word
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        chk("ferr_count", err_cnt, 1);
        chk("ferr_no_word", valid_cnt, 1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        chk("ferr_valid_count", valid_cnt, 2);
        chk("ferr_word", rx_data, 32'h0403_0201);
        chk("ferr_count_after", err_cnt, 1);

        // Single word transmit, bytes back to back
        tx_bytes.delete();
        tx_starts.delete();
        push(32'hA5C3_0F81);
        c = 0;
        while (!tx_busy && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("tx_busy_rise", tx_busy, 1);
        c = 0;
        while (tx_busy && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk("tx_busy_fall", tx_busy, 0);
        chk("tx_nbytes", tx_bytes.size(), 4);
        chk("tx_idle_line", tx, 1);
        if (tx_bytes.size() == 4) begin
            chk("tx_b0", tx_bytes[0], 8'h81);
            chk("tx_b1", tx_bytes[1], 8'h0F);
            chk("tx_b2", tx_bytes[2], 8'hC3);
            chk("tx_b3", tx_bytes[3], 8'hA5);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("tx_gap%0d", k), tx_starts[k+1] - tx_starts[k], 160);
            end
        end

        // FIFO fills while no ticks hold TX off
        tick_en = 1'b0;
        repeat (4) @(negedge clk);
        tx_bytes.delete();
        tx_starts.delete();
        for (int i = 0; i < 9; i++) words[i] = 32'h1020_3040 + 32'h0101_0101 * i;
        for (int i = 0; i < 9; i++) begin
            push(words[i]);
            if (i == 6) chk("fifo_not_full_7", full, 0);
            if (i == 7) begin
                chk("fifo_full_8", full, 1);
                chk("fifo_no_ovf_8", overflow, 0);
            end
            if (i == 8) chk("fifo_ovf_9", overflow, 1);
        end
        @(negedge clk);
        chk("fifo_ovf_pulse_end", overflow, 0);
        chk("fifo_still_full", full, 1);
        tick_en = 1'b1;
        c = 0;
        while (tx_bytes.size() < 32 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        repeat (1000) @(negedge clk);
        chk("fifo_nbytes", tx_bytes.size(), 32);
        chk("fifo_drained_full", full, 0);
        if (tx_bytes.size() == 32) begin
            for (int w = 0; w < 8; w++) begin
                chk($sformatf("fifo_word%0d", w),
                    {tx_bytes[4*w+3], tx_bytes[4*w+2], tx_bytes[4*w+1], tx_bytes[4*w]}, words[w]);
            end
        end

        // Reset during the second byte of a word, with another word queued
        tx_bytes.delete();
        tx_starts.delete();
        push(32'h1122_3344);
        push(32'h5566_7788);
        c = 0;
        while (tx_bytes.size() < 1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("rst_mid_first_byte", tx_bytes.size(), 1);
        wait_ticks(40);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", tx_busy, 0);
        chk("rst_mid_full", full, 0);
        reset = 1'b0;
        any_busy = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (tx_busy) any_busy = 1'b1;
        end
        chk("rst_fifo_empty", any_busy, 0);
        tx_bytes.delete();
        tx_starts.delete();
        push(32'hDEAD_BEEF);
        c = 0;
        while (tx_bytes.size() < 4 && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk("post_rst_nbytes", tx_bytes.size(), 4);
        if (tx_bytes.size() == 4) begin
            chk("post_rst_word", {tx_bytes[3], tx_bytes[2], tx_bytes[1], tx_bytes[0]}, 32'hDEAD_BEEF);
        end
        chk("tx_framing", tx_badstop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
